// File: rtl/bsr_pkg.sv
// Shared constants and operation decode for the boundary-scan register chain.
package bsr_pkg;

  localparam int NUM_SEG_DEF = 6;
  localparam int SEG_W_DEF   = 32;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_CAPTURE,
    OP_SHIFT,
    OP_UPDATE
  } op_e;

  // Capture wins over shift, shift over update; at most one op per edge.
  function automatic op_e decode_op(input logic cap, input logic sh, input logic upd);
    if (cap)      return OP_CAPTURE;
    else if (sh)  return OP_SHIFT;
    else if (upd) return OP_UPDATE;
    else          return OP_IDLE;
  endfunction

endpackage

// File: rtl/bsr_seg.sv
// One scan segment: shift stage, update register, bypass flop and serial output mux.
module bsr_seg
  import bsr_pkg::*;
#(
  parameter int SEG_W = SEG_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  op_e              op_i,
  input  logic             cap_en_i,
  input  logic             en_i,
  input  logic             ser_i,
  output logic             ser_o,
  input  logic [SEG_W-1:0] par_i,
  output logic [SEG_W-1:0] upd_o
);

  logic [SEG_W-1:0] shift_q, shift_d;
  logic [SEG_W-1:0] upd_q, upd_d;
  logic             byp_q, byp_d;

  // en_i is the latched enable; cap_en_i is the live enable being latched at capture.
  always_comb begin
    shift_d = shift_q;
    upd_d   = upd_q;
    byp_d   = byp_q;
    case (op_i)
      OP_CAPTURE: begin
        if (cap_en_i) shift_d = par_i;
        byp_d = 1'b0;
      end
      OP_SHIFT: begin
        if (en_i) shift_d = {ser_i, shift_q[SEG_W-1:1]};
        else      byp_d   = ser_i;
      end
      OP_UPDATE: begin
        if (en_i) upd_d = shift_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      shift_q <= '0;
      upd_q   <= '0;
      byp_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      upd_q   <= upd_d;
      byp_q   <= byp_d;
    end
  end

  assign ser_o = en_i ? shift_q[0] : byp_q;
  assign upd_o = upd_q;

endmodule

// File: rtl/bsr_chain.sv
// Segmented boundary-scan register chain with per-segment bypass.
// Define BSR_CHAIN_SHIFT_CNT_EN to build the saturating shift counter; otherwise shift_cnt is 0.
module bsr_chain
  import bsr_pkg::*;
#(
  parameter int NUM_SEG = NUM_SEG_DEF,
  parameter int SEG_W   = SEG_W_DEF
) (
  input  logic                                  tck,
  input  logic                                  trst,
  input  logic                                  tdi,
  output logic                                  tdo,
  input  logic                                  capture_dr,
  input  logic                                  shift_dr,
  input  logic                                  update_dr,
  input  logic                                  mode,
  input  logic [NUM_SEG-1:0]                    seg_en,
  input  logic [NUM_SEG*SEG_W-1:0]              parallel_in,
  output logic [NUM_SEG*SEG_W-1:0]              parallel_out,
  output logic [$clog2(NUM_SEG*SEG_W+1):0]      chain_len,
  output logic [$clog2(NUM_SEG*SEG_W+1):0]      shift_cnt
);

  localparam int W     = NUM_SEG * SEG_W;
  localparam int CNT_W = $clog2(W + 1) + 1;

  op_e              op;
  logic [NUM_SEG-1:0] seg_en_q, seg_en_d;
  logic [NUM_SEG:0]   link;
  logic [W-1:0]       upd_all;
  logic [CNT_W-1:0]   len;

  assign op = decode_op(capture_dr, shift_dr, update_dr);

  always_comb begin
    seg_en_d = seg_en_q;
    if (op == OP_CAPTURE) seg_en_d = seg_en;
  end

  always_ff @(posedge tck) begin
    if (!trst) seg_en_q <= '1;
    else       seg_en_q <= seg_en_d;
  end

  // Serial path runs tdi -> segment 0 -> ... -> segment NUM_SEG-1 -> tdo.
  assign link[0] = tdi;

  for (genvar k = 0; k < NUM_SEG; k++) begin : g_seg
    bsr_seg #(.SEG_W(SEG_W)) u_seg (
      .clk_i    (tck),
      .rst_ni   (trst),
      .op_i     (op),
      .cap_en_i (seg_en[k]),
      .en_i     (seg_en_q[k]),
      .ser_i    (link[k]),
      .ser_o    (link[k+1]),
      .par_i    (parallel_in[k*SEG_W +: SEG_W]),
      .upd_o    (upd_all[k*SEG_W +: SEG_W])
    );
  end

  assign tdo          = link[NUM_SEG];
  assign parallel_out = mode ? upd_all : parallel_in;

  always_comb begin
    len = '0;
    for (int k = 0; k < NUM_SEG; k++) begin
      len = len + (seg_en_q[k] ? CNT_W'(SEG_W) : CNT_W'(1));
    end
  end

  assign chain_len = len;

`ifdef BSR_CHAIN_SHIFT_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturates at all-ones so a long shift never looks like a short one.
  always_comb begin
    cnt_d = cnt_q;
    if (op == OP_CAPTURE)                 cnt_d = '0;
    else if (op == OP_SHIFT && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge tck) begin
    if (!trst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign shift_cnt = cnt_q;
`else
  assign shift_cnt = '0;
`endif

endmodule

// File: tb/tb_bsr_chain.sv
// Self-checking bench for bsr_chain with NUM_SEG=2, SEG_W=8; tdo expectations flow through a scoreboard queue.
module tb_bsr_chain;

  localparam int NUM_SEG = 2;
  localparam int SEG_W   = 8;
  localparam int W       = NUM_SEG * SEG_W;
  localparam int CNT_W   = $clog2(W + 1) + 1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef BSR_CHAIN_SHIFT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic               tck = 1'b0;
  logic               trst, tdi, tdo;
  logic               capture_dr, shift_dr, update_dr, mode;
  logic [NUM_SEG-1:0] seg_en;
  logic [W-1:0]       parallel_in, parallel_out;
  logic [CNT_W-1:0]   chain_len, shift_cnt;

  int   testsRun  = 0;
  int   failCount = 0;
  logic expQ[$];

  bsr_chain #(.NUM_SEG(NUM_SEG), .SEG_W(SEG_W)) dut (
    .tck          (tck),
    .trst         (trst),
    .tdi          (tdi),
    .tdo          (tdo),
    .capture_dr   (capture_dr),
    .shift_dr     (shift_dr),
    .update_dr    (update_dr),
    .mode         (mode),
    .seg_en       (seg_en),
    .parallel_in  (parallel_in),
    .parallel_out (parallel_out),
    .chain_len    (chain_len),
    .shift_cnt    (shift_cnt)
  );

  always #5 tck = ~tck;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int expCnt(input int n);
    if (!CNT_EN) return 0;
    return (n > CNT_MAX) ? CNT_MAX : n;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // One clock edge with the given controls; returns 1 time unit after the edge.
  task automatic applyStimulus(input logic rstN, input logic cap, input logic sh,
                               input logic upd, input logic tdiV);
    trst       = rstN;
    capture_dr = cap;
    shift_dr   = sh;
    update_dr  = upd;
    tdi        = tdiV;
    @(posedge tck);
    #1;
    trst       = 1'b1;
    capture_dr = 1'b0;
    shift_dr   = 1'b0;
    update_dr  = 1'b0;
  endtask

  task automatic shiftCheck(input string tag, input logic tdiV);
    logic e;
    if (expQ.size() == 0) begin
      testsRun++;
      failCount++;
      $display("[TB] FAIL %s: got empty scoreboard expected an entry", tag);
    end else begin
      e = expQ.pop_front();
      checkOutput(tag, 32'(tdo), 32'(e));
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, tdiV);
  endtask

  initial begin
    logic [W-1:0] pat;
    trst = 1'b0; tdi = 1'b0; capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0;
    mode = 1'b1; seg_en = '1; parallel_in = 16'h1357;

    // Reset
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_pout",  32'(parallel_out), 32'h0000);
    checkOutput("rst_cnt",   32'(shift_cnt),    32'(0));
    checkOutput("rst_len",   32'(chain_len),    32'd16);

    // Capture 0xA53C and shift it out: segment 1 LSB first, then segment 0
    parallel_in = 16'hA53C;
    pat = parallel_in;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int s = NUM_SEG - 1; s >= 0; s--)
      for (int b = 0; b < SEG_W; b++) expQ.push_back(pat[s*SEG_W + b]);
    for (int i = 0; i < W; i++) shiftCheck($sformatf("a53c_tdo%0d", i), 1'b0);
    checkOutput("a53c_cnt",  32'(shift_cnt), 32'(expCnt(16)));

    // Preload 0xBEEF: the first bit shifted travels to segment 1 bit 0
    pat = 16'hBEEF;
    for (int i = 0; i < W; i++) begin
      expQ.push_back(1'b0);
      shiftCheck($sformatf("beef_tdo%0d", i), pat[(i + SEG_W) % W]);
    end
    parallel_in = 16'h1234;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("beef_upd",  32'(parallel_out), 32'hBEEF);
    mode = 1'b0; #1;
    checkOutput("beef_m0",   32'(parallel_out), 32'h1234);
    parallel_in = 16'h5A5A; #1;
    checkOutput("beef_m0b",  32'(parallel_out), 32'h5A5A);
    mode = 1'b1; #1;

    // All three enables at once: capture only
    parallel_in = 16'h0F0F;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("sim_cnt",   32'(shift_cnt),    32'(0));
    checkOutput("sim_pout",  32'(parallel_out), 32'hBEEF);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("sim_upd",   32'(parallel_out), 32'h0F0F);

    // Bypass segment 1; seg_en change mid-shift must be ignored
    seg_en = 2'b01;
    parallel_in = 16'h7700;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("byp_len",   32'(chain_len), 32'd9);
    seg_en = 2'b10;
    for (int i = 0; i < 9; i++) begin
      expQ.push_back(1'b0);
      shiftCheck($sformatf("byp_tdo%0d", i), (i == 0) ? 1'b1 : 1'b0);
    end
    expQ.push_back(1'b1);
    checkOutput("byp_len2",  32'(chain_len), 32'd9);
    checkOutput("byp_tdo9",  32'(tdo), 32'(expQ.pop_front()));
    checkOutput("byp_cnt",   32'(shift_cnt), 32'(expCnt(9)));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("byp_upd",   32'(parallel_out), 32'h0F00);

    // Long shift run exercises counter saturation
    seg_en = 2'b11;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 70; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("sat_cnt",   32'(shift_cnt), 32'(expCnt(70)));

    // Reset in the middle of a shift with segment 0 bypassed
    seg_en = 2'b10;
    parallel_in = 16'hFFFF;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("mrst_len0", 32'(chain_len), 32'd9);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("mrst_cnt0", 32'(shift_cnt), 32'(expCnt(5)));
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("mrst_cnt",  32'(shift_cnt),    32'(0));
    checkOutput("mrst_len",  32'(chain_len),    32'd16);
    checkOutput("mrst_pout", 32'(parallel_out), 32'h0000);
    for (int i = 0; i < W; i++) begin
      expQ.push_back(1'b0);
      shiftCheck($sformatf("mrst_tdo%0d", i), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
